// File: rtl/bsig_bufstat_queue.sv
// Buffer-status completion queue for the RX DMA path.
// Tracks live fill of the current buffer, turns each completed buffer into a
// record in a small FIFO read by the host, raises a coalesced completion
// interrupt (count threshold or timeout) and keeps sticky overflow accounting.
module bsig_bufstat_queue #(
  parameter int MAX_BUSRTS_BITS    = 5,
  parameter int MAX_BUSRTS         = 1 << MAX_BUSRTS_BITS,
  parameter int BUFFER_SIZE_BITS   = 16,
  parameter int MAX_BUFF_SKIP_BITS = 24,
  parameter int DATA_BITS          = 4,
  parameter int QUEUE_BITS         = 3,
  parameter int SEQ_BITS           = 16,
  parameter int TIMER_BITS         = 16,
  localparam int FILLW = BUFFER_SIZE_BITS + MAX_BUSRTS_BITS - DATA_BITS + 1,
  localparam int BURSTW = MAX_BUFF_SKIP_BITS + MAX_BUSRTS,
  localparam int RECW = SEQ_BITS + 1 + BURSTW + FILLW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  dma_en,
  input  logic                  cfg_irq_en,
  input  logic [QUEUE_BITS:0]   cfg_irq_thresh,
  input  logic [TIMER_BITS-1:0] cfg_irq_timeout,
  input  logic                  cfg_ovf_clr,
  input  logic                  tbuffer_valid,
  input  logic                  tbuffer_last,
  input  logic [FILLW-1:0]      tbuffer_data,
  input  logic                  tburst_valid,
  input  logic                  tburst_last,
  input  logic [BURSTW-1:0]     tburst_data,
  output logic                  m_stat_valid,
  input  logic                  m_stat_ready,
  output logic [RECW-1:0]       m_stat_data,
  output logic [FILLW-1:0]      stat_fill,
  output logic [QUEUE_BITS:0]   stat_pending,
  output logic                  stat_ovf,
  output logic [7:0]            ovf_cnt,
  output logic                  irq
);

  localparam int DEPTH = 1 << QUEUE_BITS;

  typedef enum logic [1:0] {IDLE, ARMED, FIRED} irq_state_t;

  logic [RECW-1:0]       mem [DEPTH];
  logic [QUEUE_BITS-1:0] wr_ptr;
  logic [QUEUE_BITS-1:0] rd_ptr;
  logic [QUEUE_BITS:0]   count;
  logic [SEQ_BITS-1:0]   seq;
  logic                  push;
  logic                  pop;
  logic                  full;
  logic                  wr_en;
  logic                  drop;
  logic [RECW-1:0]       record;
  logic [QUEUE_BITS:0]   eff_thresh;
  logic                  fire;

  irq_state_t            state, state_n;
  logic [TIMER_BITS-1:0] timer, timer_n;
  logic                  irq_n;

  // tburst_valid travels with tburst_*; the record samples tburst_* in the push cycle as-is.
  logic unused_tburst_valid;
  assign unused_tburst_valid = tburst_valid;

  assign push   = dma_en & tbuffer_valid & tbuffer_last;
  assign pop    = m_stat_valid & m_stat_ready;
  assign full   = count[QUEUE_BITS];
  assign wr_en  = push & (~full | pop);
  assign drop   = push & full & ~pop;
  assign record = {seq, tburst_last, tburst_data, tbuffer_data};

  assign m_stat_valid = (count != '0);
  assign m_stat_data  = m_stat_valid ? mem[rd_ptr] : '0;
  assign stat_pending = count;

  // Record storage; no reset needed, reads are gated by the occupancy count.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= record;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + QUEUE_BITS'(1);
      if (pop)   rd_ptr <= rd_ptr + QUEUE_BITS'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + (QUEUE_BITS+1)'(1);
        2'b01:   count <= count - (QUEUE_BITS+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Sequence number and live fill; both drop to zero while DMA is disabled.
  always_ff @(posedge clk) begin
    if (rst) begin
      seq       <= '0;
      stat_fill <= '0;
    end else if (!dma_en) begin
      seq       <= '0;
      stat_fill <= '0;
    end else begin
      if (push) begin
        seq       <= seq + SEQ_BITS'(1);
        stat_fill <= '0;
      end else if (tbuffer_valid) begin
        stat_fill <= tbuffer_data;
      end
    end
  end

  // Sticky overflow; a drop in the same cycle as a clear restarts the count at one.
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_ovf <= 1'b0;
      ovf_cnt  <= '0;
    end else if (drop) begin
      stat_ovf <= 1'b1;
      if (cfg_ovf_clr)          ovf_cnt <= 8'd1;
      else if (ovf_cnt != '1)   ovf_cnt <= ovf_cnt + 8'd1;
    end else if (cfg_ovf_clr) begin
      stat_ovf <= 1'b0;
      ovf_cnt  <= '0;
    end
  end

  assign eff_thresh = (cfg_irq_thresh == '0) ? (QUEUE_BITS+1)'(1) : cfg_irq_thresh;
  assign fire = cfg_irq_en &
                ((count >= eff_thresh) |
                 ((cfg_irq_timeout != '0) & (timer >= cfg_irq_timeout)));

  // Interrupt FSM state, coalescing timer and registered irq pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      irq   <= 1'b0;
    end else begin
      state <= state_n;
      timer <= timer_n;
      irq   <= irq_n;
    end
  end

  // Interrupt FSM next-state; the pulse fires once per pending episode until a full drain.
  always_comb begin
    state_n = state;
    timer_n = timer;
    irq_n   = 1'b0;
    case (state)
      IDLE: begin
        if (count != '0) begin
          state_n = ARMED;
          timer_n = '0;
        end
      end
      ARMED: begin
        if (count == '0) begin
          state_n = IDLE;
        end else begin
          if (timer != '1) timer_n = timer + TIMER_BITS'(1);
          if (fire) begin
            irq_n   = 1'b1;
            state_n = FIRED;
          end
        end
      end
      FIRED: begin
        if (count == '0) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule
